// File: rtl/fifo_to_mem_sm.sv
// fifo_to_mem_sm: pops NUM_WORDS words from a 1-cycle-latency FIFO and writes them to
// consecutive RAM addresses from BASE_ADDR. Optional feature macro: FIFO_TO_MEM_CHECKSUM_EN.
module fifo_to_mem_sm #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int NUM_WORDS = 4,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk_mem,
    input  logic              reset_n,
    input  logic              restart,
    input  logic              start,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    output logic [1:0]        o_dbg_state
);

    // Counters must hold the value NUM_WORDS itself, which can be 2**ADDR_W.
    localparam int                CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0]  ALL_WORDS = CNT_W'(NUM_WORDS);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_fifo_rd;
    logic               w_start_xfer;
    logic [CNT_W-1:0]   r_rd_cnt;
    logic [CNT_W-1:0]   r_wr_cnt;
    logic               r_rd_pend;
    logic               r_ram_we;
    logic [ADDR_W-1:0]  r_ram_addr;
    logic [DATA_W-1:0]  r_ram_data;

    // FIFO handshake: fifo_rd is a pop request issued only while !fifo_empty; the popped
    // word appears on fifo_data the following cycle, tracked by r_rd_pend.
    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_fifo_rd    = 1'b0;
        w_start_xfer = 1'b0;
        if (restart) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_next_state = S_READ;
                        w_start_xfer = 1'b1;
                    end
                end
                S_READ: begin
                    w_fifo_rd = !fifo_empty && (r_rd_cnt < ALL_WORDS);
                    if (w_fifo_rd && (r_rd_cnt == LAST_WORD)) begin
                        w_next_state = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (r_wr_cnt == ALL_WORDS) begin
                        w_next_state = S_DONE;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Read/write pipeline: a pop in cycle k becomes a RAM write strobe in cycle k+2.
    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
            r_rd_pend  <= 1'b0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_data <= '0;
        end else if (restart) begin
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_rd_pend <= 1'b0;
            r_ram_we  <= 1'b0;
        end else if (w_start_xfer) begin
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_rd_pend <= 1'b0;
            r_ram_we  <= 1'b0;
        end else begin
            r_rd_pend <= w_fifo_rd;
            if (w_fifo_rd) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
            if (r_rd_pend) begin
                r_ram_data <= fifo_data;
                r_ram_addr <= BASE + r_wr_cnt[ADDR_W-1:0];
                r_ram_we   <= 1'b1;
                r_wr_cnt   <= r_wr_cnt + 1'b1;
            end else begin
                r_ram_we <= 1'b0;
            end
        end
    end

`ifdef FIFO_TO_MEM_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            r_checksum <= '0;
        end else if (restart || w_start_xfer) begin
            r_checksum <= '0;
        end else if (r_rd_pend) begin
            r_checksum <= r_checksum + fifo_data;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

    assign fifo_rd     = w_fifo_rd;
    assign ram_we      = r_ram_we;
    assign ram_ce      = r_ram_we;
    assign ram_addr    = r_ram_addr;
    assign ram_data    = r_ram_data;
    assign busy        = (r_state == S_READ) || (r_state == S_DRAIN);
    assign done        = (r_state == S_DONE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fifo_to_mem_sm.sv
// tb_fifo_to_mem_sm: drives a FIFO model into two fifo_to_mem_sm instances (BASE_ADDR 0 and 14)
// and scoreboards every RAM write, plus timing, restart, reset and checksum behaviour.
module tb_fifo_to_mem_sm;
  localparam int DW     = 8;
  localparam int AW     = 4;
  localparam int NW     = 4;
  localparam int BASE_B = 14;

  logic          clk_mem = 1'b0;
  logic          reset_n;
  logic          restart;
  logic          start;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data = '0;
  logic          hold_empty;

  logic          fifo_rd, ram_ce, ram_we, busy, done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data, checksum;
  logic [1:0]    dbg_state;

  logic          fifo_rd_b, ram_ce_b, ram_we_b, busy_b, done_b;
  logic [AW-1:0] ram_addr_b;
  logic [DW-1:0] ram_data_b, checksum_b;
  logic [1:0]    dbg_state_b;

  logic [DW-1:0]    fq[$];
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] exp_qb[$];
  int n_loaded  = 0;
  int n_flushed = 0;
  int n_popped  = 0;
  int xfer_idx  = 0;
  logic [DW-1:0] exp_sum;
  int n_checks  = 0;
  int n_errors  = 0;

  fifo_to_mem_sm #(.DATA_W(DW), .ADDR_W(AW), .NUM_WORDS(NW), .BASE_ADDR(0)) dut (
    .clk_mem(clk_mem), .reset_n(reset_n), .restart(restart), .start(start),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd(fifo_rd),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
    .busy(busy), .done(done), .checksum(checksum), .o_dbg_state(dbg_state)
  );

  fifo_to_mem_sm #(.DATA_W(DW), .ADDR_W(AW), .NUM_WORDS(NW), .BASE_ADDR(BASE_B)) dut_b (
    .clk_mem(clk_mem), .reset_n(reset_n), .restart(restart), .start(start),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd(fifo_rd_b),
    .ram_ce(ram_ce_b), .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_data(ram_data_b),
    .busy(busy_b), .done(done_b), .checksum(checksum_b), .o_dbg_state(dbg_state_b)
  );

  // clock / reset
  always #5 clk_mem = ~clk_mem;

  // FIFO model: 1-cycle read latency, empty flag derived from load/pop/flush counts
  assign fifo_empty = hold_empty || ((n_loaded - n_flushed) == n_popped);

  always @(posedge clk_mem) begin
    if (fifo_rd && fq.size() > 0) begin
      fifo_data <= fq.pop_front();
      n_popped  <= n_popped + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // scoreboard monitor, sampled mid-low-phase after inputs have settled
  always begin
    @(negedge clk_mem);
    #1;
    check("rd_vs_empty", 32'(fifo_rd & fifo_empty), 32'd0);
    check("ce_eq_we", 32'(ram_ce), 32'(ram_we));
    if (ram_we) begin
      check("wr_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("wr_addr_data", 32'({ram_addr, ram_data}), 32'(exp_q.pop_front()));
    end
    if (ram_we_b) begin
      check("wr_expected_b", 32'(exp_qb.size() > 0), 32'd1);
      if (exp_qb.size() > 0) check("wr_addr_data_b", 32'({ram_addr_b, ram_data_b}), 32'(exp_qb.pop_front()));
    end
  end

  // driver tasks
  task automatic new_xfer();
    xfer_idx = 0;
    exp_sum  = '0;
  endtask

  task automatic load_word(input logic [DW-1:0] d);
    fq.push_back(d);
    exp_q.push_back({AW'(xfer_idx), d});
    exp_qb.push_back({AW'(BASE_B + xfer_idx), d});
    xfer_idx++;
    exp_sum  = exp_sum + d;
    n_loaded++;
  endtask

  task automatic flush_all();
    n_flushed += fq.size();
    fq.delete();
    exp_q.delete();
    exp_qb.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk_mem);
    start = 1'b1;
    @(negedge clk_mem);
    start = 1'b0;
  endtask

  function automatic logic [DW-1:0] exp_cks(input logic [DW-1:0] s);
`ifdef FIFO_TO_MEM_CHECKSUM_EN
    return s;
`else
    return '0;
`endif
  endfunction

  task automatic wait_done(input string tag, input bit rnd_stall);
    for (int i = 0; i < 80; i++) begin
      if (done && done_b) break;
      if (rnd_stall) hold_empty = ($urandom_range(0, 2) == 0);
      @(negedge clk_mem);
    end
    hold_empty = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_done_b"}, 32'(done_b), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_sb_left_b"}, 32'(exp_qb.size()), 32'd0);
    check({tag, "_checksum"}, 32'(checksum), 32'(exp_cks(exp_sum)));
  endtask

  initial begin
    logic [DW-1:0] t1_data[4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic [DW-1:0] t5_data[4] = '{8'hFF, 8'h01, 8'h10, 8'h20};
    reset_n = 1'b0; start = 1'b0; restart = 1'b0; hold_empty = 1'b0;
    repeat (3) @(negedge clk_mem);
    check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_data", 32'(ram_data), 32'd0);
    check("rst_busy_done", 32'({busy, done}), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset_n = 1'b1;

    // back-to-back transfer with exact cycle timing
    new_xfer();
    foreach (t1_data[i]) load_word(t1_data[i]);
    pulse_start();
    for (int c = 1; c <= 8; c++) begin
      check("t1_fifo_rd", 32'(fifo_rd), 32'(c <= 4));
      check("t1_ram_we", 32'(ram_we), 32'(c >= 3 && c <= 6));
      check("t1_busy", 32'(busy), 32'(c <= 6));
      check("t1_done", 32'(done), 32'(c >= 7));
      @(negedge clk_mem);
    end
    wait_done("t1", 1'b0);

    // FIFO runs dry after the second pop for five cycles
    new_xfer();
    load_word(8'h11);
    load_word(8'h22);
    pulse_start();
    repeat (4) @(negedge clk_mem);
    for (int c = 0; c < 5; c++) begin
      check("t2_no_rd", 32'(fifo_rd), 32'd0);
      check("t2_no_we", 32'(ram_we), 32'd0);
      check("t2_busy", 32'({busy, done}), 32'b10);
      @(negedge clk_mem);
    end
    load_word(8'h33);
    load_word(8'h44);
    wait_done("t2", 1'b0);

    // restart in the cycle after the second write
    new_xfer();
    load_word(8'h5A); load_word(8'h6B); load_word(8'h7C); load_word(8'h8D);
    pulse_start();
    repeat (4) @(negedge clk_mem);
    restart = 1'b1;
    @(posedge clk_mem);
    #1;
    flush_all();
    @(negedge clk_mem);
    restart = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("t4_idle", 32'(dbg_state), 32'd0);
      check("t4_no_we", 32'(ram_we), 32'd0);
      check("t4_done", 32'(done), 32'd0);
      @(negedge clk_mem);
    end
    new_xfer();
    load_word(8'h91); load_word(8'h92); load_word(8'h93); load_word(8'h94);
    pulse_start();
    wait_done("t4", 1'b0);

    // checksum wrap
    new_xfer();
    foreach (t5_data[i]) load_word(t5_data[i]);
    pulse_start();
    wait_done("t5", 1'b0);
`ifdef FIFO_TO_MEM_CHECKSUM_EN
    check("t5_checksum_val", 32'(checksum), 32'h30);
`else
    check("t5_checksum_val", 32'(checksum), 32'h00);
`endif

    // random data with random FIFO stalls
    for (int t = 0; t < 3; t++) begin
      new_xfer();
      for (int i = 0; i < NW; i++) load_word(DW'($urandom_range(0, 255)));
      pulse_start();
      wait_done("rnd", 1'b1);
    end

    // asynchronous reset during DRAIN
    new_xfer();
    load_word(8'hE1); load_word(8'hE2); load_word(8'hE3); load_word(8'hE4);
    pulse_start();
    repeat (4) @(negedge clk_mem);
    check("t6_in_drain", 32'(dbg_state), 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_we_ce", 32'({ram_we, ram_ce}), 32'd0);
    check("t6_rst_addr", 32'(ram_addr), 32'd0);
    check("t6_rst_addr_b", 32'(ram_addr_b), 32'd0);
    check("t6_rst_data", 32'(ram_data), 32'd0);
    check("t6_rst_flags", 32'({fifo_rd, busy, done}), 32'd0);
    check("t6_rst_cks", 32'(checksum), 32'd0);
    check("t6_rst_state", 32'(dbg_state), 32'd0);
    flush_all();
    @(negedge clk_mem);
    reset_n = 1'b1;

    // start and restart together: restart wins
    new_xfer();
    load_word(8'h01); load_word(8'h02); load_word(8'h03); load_word(8'h04);
    @(negedge clk_mem);
    start = 1'b1; restart = 1'b1;
    @(negedge clk_mem);
    start = 1'b0; restart = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("t7_state", 32'(dbg_state), 32'd0);
      check("t7_idle_io", 32'({fifo_rd, ram_we, busy, done}), 32'd0);
      @(negedge clk_mem);
    end
    flush_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
